sdram_pro_rd_port: RTL and testbench

//  User-side read port for the SDRAM controller. Watches the fill level of a local read FIFO and raises
//  rd_req toward the arbiter when the FIFO has room for one burst. Supplies the burst address/length to

---
 rtl/sdram_pro_rd_port_pkg.sv | 37 +++
 rtl/sdram_pro_rd_port_if.sv | 15 +
 rtl/sdram_pro_sync_fifo.sv | 70 +++++++
 rtl/sdram_pro_rd_port.sv | 141 ++++++++++++++
 tb/tb_sdram_pro_rd_port.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_pro_rd_port_pkg.sv
// Shared types and helpers for the SDRAM read port: state codes, address field
// layout and the windowed burst-address step.
package sdram_pro_rd_port_pkg;

  localparam int ADDR_W = 23;
  localparam int LEN_W  = 10;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_REQ  = 2'd1,
    P_DONE = 2'd2
  } port_state_e;

  // SDRAM address layout: bank 22:21, row 20:9, col 8:0
  typedef struct packed {
    logic [1:0]  bank;
    logic [11:0] row;
    logic [8:0]  col;
  } sdram_addr_t;

  // Advance by one burst; rewind to the window base when the following burst
  // would run past the (exclusive) window limit.
  function automatic logic [ADDR_W-1:0] next_burst_addr(
    input logic [ADDR_W-1:0] cur,
    input logic [ADDR_W-1:0] start,
    input logic [ADDR_W-1:0] lim,
    input logic [LEN_W-1:0]  len
  );
    logic [ADDR_W-1:0] nxt;
    logic [ADDR_W:0]   nxt_end;
    nxt     = cur + ADDR_W'(len);
    nxt_end = {1'b0, nxt} + (ADDR_W+1)'(len);
    return (nxt_end > {1'b0, lim}) ? start : nxt;
  endfunction

endpackage

// File: rtl/sdram_pro_rd_port_if.sv
// Burst handshake between the read port (master) and the SDRAM reader (slave).
interface sdram_pro_rd_port_if;
  import sdram_pro_rd_port_pkg::*;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_len;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data_out;
  logic              rd_end;

  modport master (output rd_req, rd_addr, rd_len, input rd_ack, rd_data_out, rd_end);
  modport slave  (input rd_req, rd_addr, rd_len, output rd_ack, rd_data_out, rd_end);

endinterface

// File: rtl/sdram_pro_sync_fifo.sv
// Single-clock FIFO with registered read, occupancy count and synchronous clear.
module sdram_pro_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             push, pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = wr_en & ~full;
  assign pop   = rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage kept free of reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   rd_data_q <= '0;
    else if (pop) rd_data_q <= mem[rd_ptr_q];
  end

  assign rd_data = rd_data_q;
  assign count   = count_q;

endmodule

// File: rtl/sdram_pro_rd_port.sv
// SDRAM user read port: prefetches bursts into a local FIFO whenever it has room,
// walking the burst address around a user-defined window.
module sdram_pro_rd_port
  import sdram_pro_rd_port_pkg::*;
#(
  parameter int FIFO_DEPTH = 1024,
  parameter int FIFO_AW    = 10
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 init_end,
  input  logic                 rd_port_en,
  input  logic [ADDR_W-1:0]    rd_start_addr,
  input  logic [ADDR_W-1:0]    rd_end_addr,
  input  logic [LEN_W-1:0]     rd_burst_len,
  input  logic                 rd_flush,
  sdram_pro_rd_port_if.master  rd_bus,
  input  logic                 user_rd_req,
  output logic [DATA_W-1:0]    user_rd_data,
  output logic [FIFO_AW:0]     fifo_num,
  output logic                 fifo_empty,
  output logic                 rd_ovf
);

  localparam int CW = (FIFO_AW + 1 > LEN_W) ? FIFO_AW + 1 : LEN_W;

  port_state_e       state_q, state_d;
  logic              rd_req_q, rd_req_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [LEN_W-1:0]  rd_len_q, rd_len_d;
  logic              rewind_q, rewind_d;
  logic              flush_pend_q, flush_pend_d;
  logic              ovf_q, ovf_d;
  logic              rd_end_d1_q;

  logic              rd_end_rise, room_ok, flush_now, fifo_wr, fifo_full;
  logic [CW-1:0]     room;

  assign rd_end_rise = rd_bus.rd_end & ~rd_end_d1_q;
  assign room        = CW'(FIFO_DEPTH) - CW'(fifo_num);
  assign room_ok     = (room >= CW'(rd_burst_len));
  // Data of a burst caught by a flush is dropped from the flush cycle onwards
  assign fifo_wr     = rd_bus.rd_ack & ~rd_flush & ~flush_pend_q;

  always_comb begin
    state_d      = state_q;
    rd_req_d     = rd_req_q;
    rd_addr_d    = rd_addr_q;
    rd_len_d     = rd_len_q;
    rewind_d     = rewind_q;
    flush_pend_d = flush_pend_q;
    flush_now    = 1'b0;
    case (state_q)
      P_IDLE: begin
        if (rd_flush) begin
          flush_now = 1'b1;
          rewind_d  = 1'b1;
        end
        if (init_end && rd_port_en && room_ok) begin
          state_d  = P_REQ;
          rd_req_d = 1'b1;
          rd_len_d = rd_burst_len;
          if (rewind_q || rd_flush) begin
            rd_addr_d = rd_start_addr;
            rewind_d  = 1'b0;
          end
        end
      end
      P_REQ: begin
        if (rd_flush) flush_pend_d = 1'b1;
        if (rd_end_rise) begin
          state_d  = P_DONE;
          rd_req_d = 1'b0;
        end
      end
      P_DONE: begin
        state_d = P_IDLE;
        if (flush_pend_q || rd_flush) begin
          flush_now    = 1'b1;
          flush_pend_d = 1'b0;
          rewind_d     = 1'b1;
        end else begin
          rd_addr_d = next_burst_addr(rd_addr_q, rd_start_addr, rd_end_addr, rd_len_q);
        end
      end
      default: begin
        state_d  = P_IDLE;
        rd_req_d = 1'b0;
      end
    endcase

    ovf_d = ovf_q;
    if (flush_now)                  ovf_d = 1'b0;
    else if (fifo_wr && fifo_full)  ovf_d = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= P_IDLE;
      rd_req_q     <= 1'b0;
      rd_addr_q    <= '0;
      rd_len_q     <= '0;
      rewind_q     <= 1'b1;
      flush_pend_q <= 1'b0;
      ovf_q        <= 1'b0;
      rd_end_d1_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_req_q     <= rd_req_d;
      rd_addr_q    <= rd_addr_d;
      rd_len_q     <= rd_len_d;
      rewind_q     <= rewind_d;
      flush_pend_q <= flush_pend_d;
      ovf_q        <= ovf_d;
      rd_end_d1_q  <= rd_bus.rd_end;
    end
  end

  sdram_pro_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .clr     (flush_now),
    .wr_en   (fifo_wr),
    .wr_data (rd_bus.rd_data_out),
    .rd_en   (user_rd_req),
    .rd_data (user_rd_data),
    .count   (fifo_num),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rd_bus.rd_req  = rd_req_q;
  assign rd_bus.rd_addr = rd_addr_q;
  assign rd_bus.rd_len  = rd_len_q;
  assign rd_ovf         = ovf_q;

endmodule

// File: tb/tb_sdram_pro_rd_port.sv
// Directed bench for sdram_pro_rd_port with a 16-word FIFO and a scripted reader.
module tb_sdram_pro_rd_port;
  import sdram_pro_rd_port_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic              init_end, rd_port_en, rd_flush, user_rd_req;
  logic [ADDR_W-1:0] rd_start_addr, rd_end_addr;
  logic [LEN_W-1:0]  rd_burst_len;
  logic [DATA_W-1:0] user_rd_data;
  logic [AW:0]       fifo_num;
  logic              fifo_empty, rd_ovf;

  int total = 0;
  int bad   = 0;

  sdram_pro_rd_port_if rd_bus ();

  sdram_pro_rd_port #(.FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .init_end      (init_end),
    .rd_port_en    (rd_port_en),
    .rd_start_addr (rd_start_addr),
    .rd_end_addr   (rd_end_addr),
    .rd_burst_len  (rd_burst_len),
    .rd_flush      (rd_flush),
    .rd_bus        (rd_bus.master),
    .user_rd_req   (user_rd_req),
    .user_rd_data  (user_rd_data),
    .fifo_num      (fifo_num),
    .fifo_empty    (fifo_empty),
    .rd_ovf        (rd_ovf)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      $display("check %-16s observed=%0h expected=%0h ok", tag, obs, exp);
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int w;
    w = 0;
    while (rd_bus.rd_req !== 1'b1 && w < 40) begin
      step(1);
      w++;
    end
    chk(tag, 32'(rd_bus.rd_req), 32'd1);
  endtask

  task automatic acks(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      rd_bus.rd_ack      = 1'b1;
      rd_bus.rd_data_out = 16'(base + 16'(i));
      step(1);
    end
    rd_bus.rd_ack = 1'b0;
  endtask

  task automatic end_burst(input int hold);
    rd_bus.rd_end = 1'b1;
    step(hold);
    rd_bus.rd_end = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] exp);
    user_rd_req = 1'b1;
    step(1);
    user_rd_req = 1'b0;
    chk(tag, 32'(user_rd_data), 32'(exp));
  endtask

  initial begin
    int w;
    sys_rst_n          = 1'b0;
    init_end           = 1'b1;
    rd_port_en         = 1'b0;
    rd_flush           = 1'b0;
    user_rd_req        = 1'b0;
    rd_start_addr      = '0;
    rd_end_addr        = 23'h800;
    rd_burst_len       = 10'd8;
    rd_bus.rd_ack      = 1'b0;
    rd_bus.rd_data_out = '0;
    rd_bus.rd_end      = 1'b0;
    step(2);

    // reset state
    chk("rst_req",   32'(rd_bus.rd_req),  32'd0);
    chk("rst_addr",  32'(rd_bus.rd_addr), 32'd0);
    chk("rst_len",   32'(rd_bus.rd_len),  32'd0);
    chk("rst_udata", 32'(user_rd_data),   32'd0);
    chk("rst_num",   32'(fifo_num),       32'd0);
    chk("rst_empty", 32'(fifo_empty),     32'd1);
    chk("rst_ovf",   32'(rd_ovf),         32'd0);
    sys_rst_n = 1'b1;
    step(1);

    // 1: single burst of 8 from base 0
    rd_port_en = 1'b1;
    step(1);
    chk("t1_req_rise", 32'(rd_bus.rd_req),  32'd1);
    chk("t1_addr",     32'(rd_bus.rd_addr), 32'd0);
    chk("t1_len",      32'(rd_bus.rd_len),  32'd8);
    rd_port_en = 1'b0;
    step(2);
    acks(8, 16'hA000);
    end_burst(1);
    step(1);
    chk("t1_req_low",  32'(rd_bus.rd_req),  32'd0);
    chk("t1_next",     32'(rd_bus.rd_addr), 32'd8);
    chk("t1_num",      32'(fifo_num),       32'd8);
    pop_chk("t1_head", 16'hA000);
    chk("t1_num_pop",  32'(fifo_num),       32'd7);
    rd_flush = 1'b1;
    step(1);
    rd_flush = 1'b0;
    chk("t1_flush_num", 32'(fifo_num),   32'd0);
    chk("t1_flush_emp", 32'(fifo_empty), 32'd1);

    // 2: window 0x100..0x120, len 16 -> 0x100, 0x110, 0x100
    rd_start_addr = 23'h100;
    rd_end_addr   = 23'h120;
    rd_burst_len  = 10'd16;
    rd_port_en    = 1'b1;
    wait_req("t2_req1");
    chk("t2_addr1", 32'(rd_bus.rd_addr), 32'h100);
    chk("t2_len",   32'(rd_bus.rd_len),  32'd16);
    step(2);
    end_burst(1);
    wait_req("t2_req2");
    chk("t2_addr2", 32'(rd_bus.rd_addr), 32'h110);
    step(2);
    end_burst(1);
    wait_req("t2_req3");
    chk("t2_addr3", 32'(rd_bus.rd_addr), 32'h100);
    rd_port_en = 1'b0;
    step(2);
    end_burst(1);
    step(2);
    chk("t2_idle",  32'(rd_bus.rd_req),  32'd0);
    chk("t2_addr4", 32'(rd_bus.rd_addr), 32'h110);

    // 3: fill the 16-word FIFO with two bursts, then it must stall
    rd_flush = 1'b1;
    step(1);
    rd_flush      = 1'b0;
    rd_start_addr = '0;
    rd_end_addr   = 23'h800;
    rd_burst_len  = 10'd8;
    rd_port_en    = 1'b1;
    wait_req("t3_req1");
    chk("t3_addr1", 32'(rd_bus.rd_addr), 32'd0);
    step(2);
    acks(8, 16'h3000);
    end_burst(1);
    wait_req("t3_req2");
    chk("t3_addr2", 32'(rd_bus.rd_addr), 32'd8);
    step(2);
    acks(8, 16'h3008);
    end_burst(1);
    step(8);
    chk("t3_stall", 32'(rd_bus.rd_req), 32'd0);
    chk("t3_full",  32'(fifo_num),      32'd16);
    for (int i = 0; i < 8; i++) pop_chk("t3_pop", 16'(16'h3000 + 16'(i)));
    w = 0;
    while (rd_bus.rd_req !== 1'b1 && w < 2) begin
      step(1);
      w++;
    end
    chk("t3_rereq", 32'(rd_bus.rd_req),  32'd1);
    chk("t3_addr3", 32'(rd_bus.rd_addr), 32'd16);

    // 4: flush after 4 of 8 words
    step(2);
    acks(4, 16'h4000);
    chk("t4_num_mid", 32'(fifo_num), 32'd12);
    rd_flush = 1'b1;
    acks(1, 16'h4004);
    rd_flush = 1'b0;
    acks(3, 16'h4005);
    end_burst(1);
    step(1);
    chk("t4_num_done", 32'(fifo_num),   32'd0);
    chk("t4_empty",    32'(fifo_empty), 32'd1);
    wait_req("t4_req");
    chk("t4_rewind",   32'(rd_bus.rd_addr), 32'd0);

    // 5: simultaneous push/pop at 5 words, then overflow
    rd_port_en = 1'b0;
    step(2);
    acks(5, 16'h5000);
    end_burst(1);
    step(1);
    chk("t5_num5", 32'(fifo_num), 32'd5);
    for (int i = 0; i < 2; i++) begin
      rd_bus.rd_ack      = 1'b1;
      rd_bus.rd_data_out = 16'(16'h5005 + 16'(i));
      user_rd_req        = 1'b1;
      step(1);
      chk("t5_pp_num",  32'(fifo_num),     32'd5);
      chk("t5_pp_data", 32'(user_rd_data), 32'(16'h5000 + 16'(i)));
    end
    rd_bus.rd_ack = 1'b0;
    user_rd_req   = 1'b0;
    for (int i = 0; i < 5; i++) pop_chk("t5_drain", 16'(16'h5002 + 16'(i)));
    chk("t5_num0", 32'(fifo_num), 32'd0);
    pop_chk("t5_empty_pop", 16'h5006);
    chk("t5_num0b", 32'(fifo_num), 32'd0);
    acks(16, 16'h6000);
    chk("t5_full",    32'(fifo_num), 32'd16);
    chk("t5_ovf0",    32'(rd_ovf),   32'd0);
    acks(1, 16'h6010);
    chk("t5_ovf1",    32'(rd_ovf),   32'd1);
    chk("t5_full2",   32'(fifo_num), 32'd16);
    step(3);
    chk("t5_sticky",  32'(rd_ovf),   32'd1);
    pop_chk("t5_head", 16'h6000);
    rd_flush = 1'b1;
    step(1);
    rd_flush = 1'b0;
    chk("t5_ovf_clr", 32'(rd_ovf),   32'd0);
    chk("t5_num_clr", 32'(fifo_num), 32'd0);

    // 6: rd_end held high spans the next request; then async reset mid-burst
    rd_port_en = 1'b1;
    wait_req("t6_req1");
    chk("t6_addr1", 32'(rd_bus.rd_addr), 32'd0);
    step(2);
    end_burst(10);
    step(2);
    chk("t6_req2",  32'(rd_bus.rd_req),  32'd1);
    chk("t6_addr2", 32'(rd_bus.rd_addr), 32'd8);
    step(1);
    acks(3, 16'h7000);
    chk("t6_num3",  32'(fifo_num), 32'd3);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("t6_rst_req",   32'(rd_bus.rd_req),  32'd0);
    chk("t6_rst_num",   32'(fifo_num),       32'd0);
    chk("t6_rst_empty", 32'(fifo_empty),     32'd1);
    chk("t6_rst_addr",  32'(rd_bus.rd_addr), 32'd0);
    rd_port_en = 1'b0;
    step(2);
    sys_rst_n = 1'b1;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
